// File: rtl/phase_tag_averager.sv
// Phase-tag window averager: forms the signed fine delay per tag, sums 2**LOG2_N tags,
// and presents sum / floor mean / first start_cnt on a valid-ready result port.
module phase_tag_averager #(
  parameter int PHASE_COUNT_SIZE = 6,
  parameter int CLK_0_COUNT_SIZE = 6,
  parameter int LOG2_N           = 2
) (
  input  logic                                           clk_0,
  input  logic                                           rst,
  input  logic                                           en,
  input  logic                                           clear,
  input  logic [PHASE_COUNT_SIZE+CLK_0_COUNT_SIZE+3:0]   tag_in,
  input  logic                                           tag_valid,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [PHASE_COUNT_SIZE+3+LOG2_N-1:0]           sum_out,
  output logic [PHASE_COUNT_SIZE+2:0]                    avg_out,
  output logic [CLK_0_COUNT_SIZE-1:0]                    first_start,
  output logic [LOG2_N-1:0]                              fill_count,
  output logic                                           overrun
);
  localparam int P  = PHASE_COUNT_SIZE;
  localparam int C  = CLK_0_COUNT_SIZE;
  localparam int D  = P + 3;
  localparam int SW = D + LOG2_N;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Asserts immediately, releases two edges after rst drops.
  logic [1:0] rst_sync_q;
  logic       arst;
  always_ff @(posedge clk_0 or posedge rst)
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign arst = rst_sync_q[1];

  logic [C-1:0] tag_start;
  logic [P-1:0] tag_phase;
  logic [1:0]   tag_sph, tag_tph;
  assign {tag_start, tag_phase, tag_sph, tag_tph} = tag_in;

  state_t               state_q, state_d;
  logic signed [D-1:0]  diff_q, diff_d;
  logic                 diff_valid_q, diff_valid_d;
  logic [C-1:0]         start_s1_q;
  logic signed [SW-1:0] acc_q, acc_d, sum_q, sum_d, sum_in;
  logic [LOG2_N-1:0]    fill_q, fill_d;
  logic [C-1:0]         first_q, first_d, first_out_q, first_out_d;
  logic                 out_valid_q, out_valid_d, ovr_q, ovr_d;
  logic                 flush, load;

  assign diff_d = $signed({1'b0, tag_phase, 2'b00})
                + $signed({{(D-2){1'b0}}, tag_tph})
                - $signed({{(D-2){1'b0}}, tag_sph});
  assign diff_valid_d = tag_valid & en & ~clear;

  // Any cycle with en low (or clear) abandons the window and any diff in flight.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      IDLE:  begin
        flush = 1'b1;
        if (en) state_d = ACCUM;
      end
      ACCUM: if (!en) begin
        state_d = IDLE;
        flush   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (clear) flush = 1'b1;
  end

  assign sum_in = (fill_q == '0 ? '0 : acc_q) + {{LOG2_N{diff_q[D-1]}}, diff_q};

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    first_d     = first_q;
    load        = 1'b0;
    sum_d       = sum_q;
    first_out_d = first_out_q;
    out_valid_d = out_valid_q;
    ovr_d       = ovr_q;
    if (flush) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (diff_valid_q) begin
      acc_d  = sum_in;
      fill_d = fill_q + LOG2_N'(1);
      if (fill_q == '0) first_d = start_s1_q;
      if (&fill_q)      load    = 1'b1;
    end
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        sum_d       = sum_in;
        first_out_d = first_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clear) begin
      out_valid_d = 1'b0;
      ovr_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_0 or posedge arst)
    if (arst) begin
      state_q      <= IDLE;
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
      start_s1_q   <= '0;
      acc_q        <= '0;
      fill_q       <= '0;
      first_q      <= '0;
      sum_q        <= '0;
      first_out_q  <= '0;
      out_valid_q  <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      diff_valid_q <= diff_valid_d;
      if (tag_valid) begin
        diff_q     <= diff_d;
        start_s1_q <= tag_start;
      end
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      first_q      <= first_d;
      sum_q        <= sum_d;
      first_out_q  <= first_out_d;
      out_valid_q  <= out_valid_d;
      ovr_q        <= ovr_d;
    end

  assign out_valid   = out_valid_q;
  assign sum_out     = sum_q;
  assign avg_out     = sum_q[SW-1:LOG2_N];
  assign first_start = first_out_q;
  assign fill_count  = fill_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_phase_tag_averager.sv
// Scoreboard bench for phase_tag_averager: tag tasks model the window sums,
// a negedge monitor pops and checks each accepted result.
module tb_phase_tag_averager;
  localparam int P = 6, C = 6, L = 2, N = 4, D = P + 3;

  logic clk_0 = 1'b0;
  logic rst, en, clear, tag_valid, out_ready;
  logic [P+C+3:0] tag_in;
  logic out_valid, overrun;
  logic [D+L-1:0] sum_out;
  logic [D-1:0]   avg_out;
  logic [C-1:0]   first_start;
  logic [L-1:0]   fill_count;

  phase_tag_averager #(.PHASE_COUNT_SIZE(P), .CLK_0_COUNT_SIZE(C), .LOG2_N(L)) dut (
    .clk_0(clk_0), .rst(rst), .en(en), .clear(clear), .tag_in(tag_in),
    .tag_valid(tag_valid), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .avg_out(avg_out), .first_start(first_start),
    .fill_count(fill_count), .overrun(overrun));

  always #5 clk_0 = ~clk_0;

  typedef struct { int sum; int first; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_acc = 0;
  int m_cnt = 0, m_acc = 0, m_first = 0;
  bit m_ovr = 0;

  always @(negedge clk_0) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_acc++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result got sum=%0d, none expected", $signed(sum_out));
      end else begin
        e = q.pop_front();
        if (int'($signed(sum_out)) !== e.sum) begin
          n_bad++; $display("FAIL sum_out got %0d want %0d", $signed(sum_out), e.sum);
        end
        n_cmp++;
        if (int'($signed(avg_out)) !== (e.sum >>> L)) begin
          n_bad++; $display("FAIL avg_out got %0d want %0d", $signed(avg_out), e.sum >>> L);
        end
        n_cmp++;
        if (int'(first_start) !== e.first) begin
          n_bad++; $display("FAIL first_start got %0d want %0d", first_start, e.first);
        end
      end
    end
  end

  task automatic tag(input int ph, input int sph, input int tph, input int sc);
    @(posedge clk_0); #1;
    tag_in    = {C'(sc), P'(ph), 2'(sph), 2'(tph)};
    tag_valid = 1'b1;
    if (en) begin
      if (m_cnt == 0) m_first = sc;
      m_acc += ph * 4 + tph - sph;
      m_cnt++;
      if (m_cnt == N) begin
        if (!out_ready && q.size() > 0) m_ovr = 1;
        else q.push_back('{m_acc, m_first});
        m_cnt = 0; m_acc = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk_0); #1 tag_valid = 1'b0;
    repeat (n) @(posedge clk_0);
    #1;
  endtask

  task automatic model_flush();
    m_cnt = 0; m_acc = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk_0);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; clear = 0; tag_valid = 0; out_ready = 1; tag_in = '0;
    repeat (2) @(negedge clk_0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (sum_out !== '0) begin n_bad++; $display("FAIL rst_sum got %0d want 0", sum_out); end
    n_cmp++; if (fill_count !== '0) begin n_bad++; $display("FAIL rst_fill got %0d want 0", fill_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %0b want 0", overrun); end
    @(posedge clk_0); #1 rst = 0;
    repeat (4) @(posedge clk_0);
    #1 en = 1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) tag(5, 1, 3, 9 + i);
    @(posedge clk_0); #1 tag_valid = 0;
    @(negedge clk_0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid got %0b want 0", out_valid); end
    n_cmp++; if (fill_count !== 2'd3) begin n_bad++; $display("FAIL fill_mid got %0d want 3", fill_count); end
    @(negedge clk_0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_valid got %0b want 1", out_valid); end
    drain();
  endtask

  task automatic test_negative();
    for (int i = 0; i < 3; i++) tag(0, 3, 0, 20 + i);
    tag(0, 0, 0, 30);
    idle(3);
    drain();
  endtask

  task automatic test_overrun();
    out_ready = 0;
    for (int i = 0; i < 8; i++) tag(1, 0, 0, 40 + i);
    idle(3);
    @(negedge clk_0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got %0b want 1", out_valid); end
    n_cmp++; if (int'($signed(sum_out)) !== q[0].sum) begin n_bad++; $display("FAIL hold_sum got %0d want %0d", $signed(sum_out), q[0].sum); end
    n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL overrun got %0b want %0b", overrun, m_ovr); end
    @(posedge clk_0); #1 clear = 1;
    @(posedge clk_0); #1 clear = 0;
    q.delete(); m_ovr = 0; model_flush();
    @(negedge clk_0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid got %0b want 0", out_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL clear_overrun got %0b want 0", overrun); end
    out_ready = 1;
  endtask

  task automatic test_en_toggle();
    int a0;
    a0 = n_acc;
    tag(0, 0, 1, 50); tag(0, 0, 1, 51);
    @(posedge clk_0); #1 tag_valid = 0; en = 0; model_flush();
    @(posedge clk_0); #1 en = 1;
    for (int i = 0; i < 4; i++) tag(0, 0, 1, 52 + i);
    idle(3);
    drain();
    n_cmp++; if (n_acc - a0 !== 1) begin n_bad++; $display("FAIL en_results got %0d want 1", n_acc - a0); end
  endtask

  task automatic test_reset_mid();
    int a0;
    a0 = n_acc;
    for (int i = 0; i < 3; i++) tag(0, 0, 2, 60 + i);
    @(posedge clk_0); #1 tag_valid = 0; rst = 1; model_flush();
    @(negedge clk_0);
    n_cmp++; if ({out_valid, overrun} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_flags got %b want 00", {out_valid, overrun}); end
    n_cmp++; if (sum_out !== '0 || avg_out !== '0) begin n_bad++; $display("FAIL mid_rst_data got %0d/%0d want 0/0", sum_out, avg_out); end
    n_cmp++; if (first_start !== '0 || fill_count !== '0) begin n_bad++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", first_start, fill_count); end
    @(posedge clk_0); #1 rst = 0;
    repeat (4) @(posedge clk_0);
    for (int i = 0; i < 4; i++) tag(0, 0, 2, 1 + i);
    idle(3);
    drain();
    n_cmp++; if (n_acc - a0 !== 1) begin n_bad++; $display("FAIL rst_results got %0d want 1", n_acc - a0); end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = n_acc;
    for (int i = 0; i < 12; i++) tag(63, 0, 3, i);
    idle(3);
    drain();
    n_cmp++; if (n_acc - a0 !== 3) begin n_bad++; $display("FAIL b2b_results got %0d want 3", n_acc - a0); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %0b want 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overrun();
    test_en_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
